alu181_serial_ctrl: RTL and testbench

//   Sequencer that runs one WIDTH-bit 74181-style ALU operation on a single

---
 rtl/alu181_serial_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu181_serial_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu181_serial_ctrl.sv
// Nibble-serial sequencer for one external 74181 slice: a WIDTH-bit operation
// is performed LSB nibble first, one nibble per clock, with a registered ripple carry.
module alu181_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             equal,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic [3:0]       slice_s,
    output logic             slice_m,
    output logic             slice_cn,
    input  logic [3:0]       slice_f,
    input  logic             slice_cn4,
    input  logic             slice_equal,
    output logic [1:0]       state_dbg
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;
    logic [3:0]       s_l;
    logic             m_l;
    logic             carry_reg;
    logic             eq_acc;
    logic [WIDTH-1:0] f_acc;
    logic [WIDTH-1:0] f_r;
    logic             cout_r;
    logic             equal_r;

    logic             in_run;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [WIDTH-1:0] f_next;

    // Handshake: start is sampled only in IDLE; busy covers the NIBBLES RUN
    // cycles; done is a single-cycle pulse during which f/cout/equal are valid,
    // and those stay held until the next accepted start completes.
    assign in_run    = (state == S_RUN);
    assign busy      = in_run;
    assign done      = (state == S_DONE);
    assign state_dbg = state;
    assign f         = f_r;
    assign cout      = cout_r;
    assign equal     = equal_r;

    // Nibble selection and result merge; f_next already contains the current
    // slice result so the final nibble can be published on the exit edge.
    always_comb begin
        a_nib  = 4'h0;
        b_nib  = 4'h0;
        f_next = f_acc;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) begin
                a_nib              = a_l[4*n +: 4];
                b_nib              = b_l[4*n +: 4];
                f_next[4*n +: 4]   = slice_f;
            end
        end
    end

    assign slice_a  = in_run ? a_nib : 4'h0;
    assign slice_b  = in_run ? b_nib : 4'h0;
    assign slice_s  = in_run ? s_l   : 4'h0;
    assign slice_m  = in_run & m_l;
    assign slice_cn = in_run & carry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            a_l       <= '0;
            b_l       <= '0;
            s_l       <= 4'h0;
            m_l       <= 1'b0;
            carry_reg <= 1'b0;
            eq_acc    <= 1'b0;
            f_acc     <= '0;
            f_r       <= '0;
            cout_r    <= 1'b1;
            equal_r   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_l       <= a;
                        b_l       <= b;
                        s_l       <= s;
                        m_l       <= m;
                        carry_reg <= cn;
                        eq_acc    <= 1'b1;
                        f_acc     <= '0;
                        idx       <= '0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    f_acc     <= f_next;
                    carry_reg <= slice_cn4;
                    eq_acc    <= eq_acc & slice_equal;
                    if (idx == LAST_IDX) begin
                        f_r     <= f_next;
                        cout_r  <= slice_cn4;
                        equal_r <= eq_acc & slice_equal;
                        state   <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu181_serial_ctrl.sv
// Bench for alu181_serial_ctrl: a behavioural 74181 slice answers the DUT's
// slice port, and a word-level datasheet model predicts each full result.
module tb_alu181_serial_ctrl;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             equal;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_s;
    logic             slice_m;
    logic             slice_cn;
    logic [3:0]       slice_f;
    logic             slice_cn4;
    logic             slice_equal;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [WIDTH-1:0] held_f = '0;
    logic [WIDTH+1:0] exp_q[$];

    alu181_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .cn(cn),
        .busy(busy), .done(done), .f(f), .cout(cout), .equal(equal),
        .slice_a(slice_a), .slice_b(slice_b), .slice_s(slice_s), .slice_m(slice_m),
        .slice_cn(slice_cn), .slice_f(slice_f), .slice_cn4(slice_cn4),
        .slice_equal(slice_equal), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // ---------------- external 74181 slice (gate-level view) ----------------
    function automatic logic [5:0] slice_model(input logic [3:0] sa, input logic [3:0] sb,
                                               input logic [3:0] ss, input logic sm,
                                               input logic scn);
        logic [3:0] x, y, ff;
        logic [4:0] sum;
        x   = sa | (ss[0] ? sb : 4'h0) | (ss[1] ? ~sb : 4'h0);
        y   = (ss[3] ? (sa & sb) : 4'h0) | (ss[2] ? (sa & ~sb) : 4'h0);
        sum = {1'b0, x} + {1'b0, y} + {4'b0, ~scn};
        ff  = sm ? ~(x ^ y) : sum[3:0];
        return {&ff, ~sum[4], ff};
    endfunction

    always_comb {slice_equal, slice_cn4, slice_f} = slice_model(slice_a, slice_b, slice_s, slice_m, slice_cn);

    // ---------------- word-level datasheet reference: {equal, cout, f} ----------------
    function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                                input logic [3:0] rs, input logic rm, input logic rcn);
        logic [WIDTH-1:0] pa, qa, lf, rf, ones;
        logic [WIDTH:0]   sum;
        ones = '1;
        case (rs)
            4'd0:  begin pa = ra;       qa = '0;       end
            4'd1:  begin pa = ra | rb;  qa = '0;       end
            4'd2:  begin pa = ra | ~rb; qa = '0;       end
            4'd3:  begin pa = ones;     qa = '0;       end
            4'd4:  begin pa = ra;       qa = ra & ~rb; end
            4'd5:  begin pa = ra | rb;  qa = ra & ~rb; end
            4'd6:  begin pa = ra;       qa = ~rb;      end
            4'd7:  begin pa = ra & ~rb; qa = ones;     end
            4'd8:  begin pa = ra;       qa = ra & rb;  end
            4'd9:  begin pa = ra;       qa = rb;       end
            4'd10: begin pa = ra | ~rb; qa = ra & rb;  end
            4'd11: begin pa = ra & rb;  qa = ones;     end
            4'd12: begin pa = ra;       qa = ra;       end
            4'd13: begin pa = ra | rb;  qa = ra;       end
            4'd14: begin pa = ra | ~rb; qa = ra;       end
            default: begin pa = ra;     qa = ones;     end
        endcase
        case (rs)
            4'd0:  lf = ~ra;
            4'd1:  lf = ~(ra | rb);
            4'd2:  lf = ~ra & rb;
            4'd3:  lf = '0;
            4'd4:  lf = ~(ra & rb);
            4'd5:  lf = ~rb;
            4'd6:  lf = ra ^ rb;
            4'd7:  lf = ra & ~rb;
            4'd8:  lf = ~ra | rb;
            4'd9:  lf = ~(ra ^ rb);
            4'd10: lf = rb;
            4'd11: lf = ra & rb;
            4'd12: lf = ones;
            4'd13: lf = ra | ~rb;
            4'd14: lf = ra | rb;
            default: lf = ra;
        endcase
        sum = {1'b0, pa} + {1'b0, qa} + {{WIDTH{1'b0}}, ~rcn};
        rf  = rm ? lf : sum[WIDTH-1:0];
        return {&rf, ~sum[WIDTH], rf};
    endfunction

    // ---------------- driver helpers ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 4 * NIBBLES) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic chk_cout);
        logic [WIDTH+1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (f !== e[WIDTH-1:0]) begin
            errors++;
            $display("FAIL %s f: got %h expected %h", name, f, e[WIDTH-1:0]);
        end
        checks++;
        if (equal !== e[WIDTH+1]) begin
            errors++;
            $display("FAIL %s equal: got %b expected %b", name, equal, e[WIDTH+1]);
        end
        if (chk_cout) begin
            checks++;
            if (cout !== e[WIDTH]) begin
                errors++;
                $display("FAIL %s cout: got %b expected %b", name, cout, e[WIDTH]);
            end
        end
        held_f = e[WIDTH-1:0];
    endtask

    // One full operation; poke re-asserts start mid-RUN and during DONE.
    task automatic do_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic [3:0] ts, input logic tm, input logic tcn, input logic poke);
        int lat;
        int d0;
        exp_q.push_back(ref_op(ta, tb_v, ts, tm, tcn));
        @(negedge clk);
        d0 = done_cnt;
        a = ta; b = tb_v; s = ts; m = tm; cn = tcn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || f !== held_f) begin
            errors++;
            $display("FAIL %s accept: busy %b f %h, expected busy 1 f %h", name, busy, f, held_f);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 4 * NIBBLES) begin
            @(negedge clk);
            lat++;
            start = poke && (lat == 1);
        end
        checks++;
        if (lat !== NIBBLES) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, NIBBLES);
        end
        checks++;
        if (busy !== 1'b0 || slice_a !== 4'h0 || slice_s !== 4'h0 || slice_cn !== 1'b0) begin
            errors++;
            $display("FAIL %s done-cycle outputs: busy %b slice_a %h slice_s %h slice_cn %b, expected all 0",
                     name, busy, slice_a, slice_s, slice_cn);
        end
        check_result(name, !tm);
        start = poke;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || f !== held_f) begin
            errors++;
            $display("FAIL %s after done: done %b busy %b f %h, expected 0 0 %h", name, done, busy, f, held_f);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt - d0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; s = 4'h0; m = 1'b0; cn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || f !== '0 || cout !== 1'b1 || equal !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: busy %b done %b f %h cout %b equal %b, expected 0 0 0000 1 0",
                     busy, done, f, cout, equal);
        end
        checks++;
        if (slice_a !== 4'h0 || slice_b !== 4'h0 || slice_s !== 4'h0 || slice_m !== 1'b0 || slice_cn !== 1'b0) begin
            errors++;
            $display("FAIL reset slice: a %h b %h s %h m %b cn %b, expected all 0",
                     slice_a, slice_b, slice_s, slice_m, slice_cn);
        end
        rst = 1'b0;
        held_f = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset idle: busy %b done %b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        do_op("add",       16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1, 1'b0);
        do_op("ripple",    16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
        do_op("cmp_eq",    16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 1'b0);
        do_op("cmp_ne",    16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, 1'b0);
        do_op("xor_poke",  16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 1'b1);
        do_op("add_carry", 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op("random", WIDTH'($urandom), WIDTH'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_run();
        int d0;
        logic [WIDTH-1:0] ta;
        ta = 16'hABCD;
        @(negedge clk);
        a = ta; b = 16'h1357; s = 4'b1001; m = 1'b0; cn = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (slice_a !== ta[11:8] || slice_b !== 4'h3 || slice_s !== 4'b1001 || slice_m !== 1'b0) begin
            errors++;
            $display("FAIL midrun slice nibble2: a %h b %h s %h m %b, expected %h 3 9 0",
                     slice_a, slice_b, slice_s, slice_m, ta[11:8]);
        end
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || f !== '0 || cout !== 1'b1 || equal !== 1'b0) begin
            errors++;
            $display("FAIL midrun reset: busy %b done %b f %h cout %b equal %b, expected 0 0 0000 1 0",
                     busy, done, f, cout, equal);
        end
        held_f = '0;
        repeat (NIBBLES + 3) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun abandon: done pulses %0d busy %b, expected 0 0", done_cnt - d0, busy);
        end
        do_op("after_reset", 16'h0F0F, 16'h0101, 4'b1001, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lat;
        int d0;
        logic [WIDTH-1:0] f1;
        exp_q.push_back(ref_op(16'h1000, 16'h2000, 4'b1001, 1'b0, 1'b1));
        exp_q.push_back(ref_op(16'h8421, 16'h1248, 4'b0110, 1'b1, 1'b1));
        @(negedge clk);
        d0 = done_cnt;
        a = 16'h1000; b = 16'h2000; s = 4'b1001; m = 1'b0; cn = 1'b1; start = 1'b1;
        @(negedge clk);
        a = 16'h8421; b = 16'h1248; s = 4'b0110; m = 1'b1;
        wait_done(lat);
        checks++;
        if (lat !== NIBBLES) begin
            errors++;
            $display("FAIL b2b first latency: got %0d expected %0d", lat, NIBBLES);
        end
        check_result("b2b_first", 1'b1);
        f1 = held_f;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || f !== f1) begin
            errors++;
            $display("FAIL b2b idle gap: busy %b done %b f %h, expected 0 0 %h", busy, done, f, f1);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || f !== f1) begin
            errors++;
            $display("FAIL b2b second accept: busy %b f %h, expected 1 %h", busy, f, f1);
        end
        wait_done(lat);
        checks++;
        if (lat !== NIBBLES) begin
            errors++;
            $display("FAIL b2b second latency: got %0d expected %0d", lat, NIBBLES);
        end
        check_result("b2b_second", 1'b0);
        @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 2 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b done pulses: got %0d done %b, expected 2 0", done_cnt - d0, done);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
